ariane_emc_prog: RTL and testbench
==================================

Name: ariane_emc_prog

Overview:
- APB-programmable write/erase engine for the board's 16-bit parallel NOR flash (Intel/Micron CFI command set, x16, byte address with bit 0 ignored).
- Provides the write direction that the existing read-only flash window lacks. Software loads address/data registers and issues a command. The block emits the CFI bus-cycle sequence, polls the flash status register, then returns the flash to read-array mode.
- Sits on its own APB slot beside the read window. Flash pins are muxed externally; the engine owns the bus while busy.

Parameters:
- WE_LOW_CYCLES, 3, clk cycles flash_we_b held low per write cycle (50 MHz: 60 ns).
- READ_WAIT_CYCLE, 6, extra clk cycles oe_b held low before data capture.
- POLL_LIMIT, 2^24-1, max status reads before timeout error.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous active-high reset
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB write
- paddr  in  32  APB address; only [3:2] decoded
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  APB ready
- pslverr  out  1  APB error, tied 0
- flash_dq_i  in  16  flash data in
- flash_dq_o  out  16  flash data out
- flash_dq_t  out  16  tristate control, 1 = high-Z, all bits identical
- flash_a  out  27  flash byte address, bit 0 = 0
- flash_we_b, flash_oe_b, flash_ce_b, flash_adv_b  out  1 each  active-low strobes; adv_b tied 0
- flash_wait  in  1  ignored

Behaviour:
Reset values:
- prdata=0, pready=1; ce_b/oe_b/we_b=1; dq_t=all 1; dq_o=0; flash_a=0.
- ADDR=0, DATA=0, STATUS=0, state IDLE.

Registers (paddr[3:2]):
- 0 ADDR: RW, [26:0].
- 1 DATA: RW, [15:0].
- 2 CMD: W-only, reads 0. Values: 1 = program word, 2 = erase block, 3 = unlock block.
- 3 STATUS: R-only. bit0 busy, bit1 done (sticky), bit2 error (sticky), [15:8] last flash SR byte.

APB:
- Zero wait state: pready=1 always. Writes take effect on the access-phase edge (psel&penable&pwrite). prdata is combinational from the registers during access.
- While busy, writes to ADDR/DATA/CMD are ignored, with no error.
- A CMD write in IDLE clears done/error. Busy is set the next cycle.
- Unknown CMD value: done=1, error=1, no flash activity.

Write cycle (W):
- Setup, 1 cycle: ce_b=0, dq_t=0, a/dq valid.
- WE_LOW_CYCLES cycles with we_b=0.
- Hold, 1 cycle: we_b=1, still driving.
- Recovery, 1 cycle: ce_b=1, dq_t=1.
- Total 6 cycles at default.

Read cycle (R):
- ce_b=oe_b=0, dq_t=1 for READ_WAIT_CYCLE+1 cycles; flash_dq_i captured on the last.
- Then 1 recovery cycle with ce_b=oe_b=1.
- Total 8 cycles at default.

Command sequences (all write cycles to ADDR):
- Unlock: W 0x0050 (clear SR), W 0x0060, W 0x00D0, W 0x00FF, DONE.
- Program: W 0x0050, W 0x0040, W DATA, POLL, W 0x00FF, DONE.
- Erase: W 0x0050, W 0x0020, W 0x00D0, POLL, W 0x00FF, DONE.

POLL:
- After the data/confirm write the flash is in SR mode. Repeat R until dq[7]=1; latch dq[7:0] into STATUS[15:8].
- error=1 if SR[5:1]≠0.
- Counter reaching POLL_LIMIT reads without SR7 sets error and proceeds to W 0x00FF.

DONE (1 cycle): busy→0, done=1. A CMD write in the same cycle is ignored; it is accepted from IDLE only.

Reset mid-operation: immediate return to reset values. The flash may be left in a non-array mode; software re-issues the command.

Test Plan:
- Reset, then APB read STATUS → 0x0; write ADDR=0x0012346, read back → 0x0012346; pready=1 every access.
- Write DATA=0xBEEF, CMD=1, flash model returns SR=0x80 on first poll:
  - Bus sequence: W(0x12346,0x0050), W(0x0040), W(0xBEEF), one 8-cycle R, W(0x00FF).
  - Each W is 6 cycles with we_b low exactly 3 cycles.
  - STATUS ends 0x8002.
- CMD=2, model returns SR=0x00 ×5 then 0xA0: 6 reads issued, confirm word 0x00D0, STATUS → 0xA006 (done+error, SR5 set).
- CMD=1 while busy and write ADDR while busy: both ignored, sequence and flash_a unchanged. CMD=7 from IDLE → STATUS=0x0006, ce_b stays 1.
- POLL_LIMIT=4, model never sets SR7: exactly 4 reads, then W 0x00FF; STATUS bit2=1, bit1=1.
- Assert rst during the we_b-low phase of a program: next cycle ce_b=we_b=1, dq_t=0xFFFF, STATUS=0.

Source files
------------

// File: rtl/ariane_emc_prog.sv
// ariane_emc_prog: APB-programmable program/erase/unlock engine for a x16
// CFI (Intel/Micron command set) parallel NOR flash. Software loads ADDR and
// DATA, writes CMD, and the engine emits the bus-cycle sequence, polls the
// flash status register and returns the part to read-array mode.
module ariane_emc_prog #(
  parameter int WE_LOW_CYCLES   = 3,
  parameter int READ_WAIT_CYCLE = 6,
  parameter int POLL_LIMIT      = (2 ** 24) - 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic [15:0] flash_dq_i,
  output logic [15:0] flash_dq_o,
  output logic [15:0] flash_dq_t,
  output logic [26:0] flash_a,
  output logic        flash_we_b,
  output logic        flash_oe_b,
  output logic        flash_ce_b,
  output logic        flash_adv_b,
  input  logic        flash_wait
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  localparam logic [1:0] CMD_PROG   = 2'd1;
  localparam logic [1:0] CMD_ERASE  = 2'd2;

  localparam logic [1:0] REG_ADDR   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CMD    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // Sequence slots: 0 clear-SR, 1 setup opcode, 2 data/confirm, 3 poll,
  // 4 read-array. Unlock has no poll and jumps from slot 2 to slot 4.
  localparam logic [2:0] IDX_CONFIRM = 3'd2;
  localparam logic [2:0] IDX_ARRAY   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_SETUP,
    ST_W_LOW,
    ST_W_HOLD,
    ST_W_REC,
    ST_R_ACT,
    ST_R_REC,
    ST_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [26:0]     addr;
  logic [15:0]     data;
  logic [1:0]      cmd;
  logic [2:0]      seq_idx;
  logic [7:0]      cyc_cnt;
  logic [PW-1:0]   poll_cnt;
  logic [7:0]      sr;
  logic            done;
  logic            error;

  logic            busy;
  logic            wr_access;
  logic            rd_access;
  logic            cmd_write;
  logic            cmd_valid;
  logic            cmd_go;
  logic            we_last;
  logic            rd_last;
  logic            poll_timeout;
  logic            poll_exit;
  logic            drive;
  logic [15:0]     write_word;
  logic            unused_ok;

  assign pready      = 1'b1;
  assign pslverr     = 1'b0;
  assign flash_adv_b = 1'b0;
  assign unused_ok   = ^{flash_wait, flash_dq_i[15:8], paddr[31:4], paddr[1:0]};

  assign wr_access    = psel & penable & pwrite;
  assign rd_access    = psel & penable & ~pwrite;
  assign busy         = (state != ST_IDLE) && (state != ST_DONE);
  // Commands are taken from IDLE only; the DONE cycle also rejects them.
  assign cmd_write    = wr_access && (paddr[3:2] == REG_CMD) && (state == ST_IDLE);
  assign cmd_valid    = (pwdata == 32'd1) || (pwdata == 32'd2) || (pwdata == 32'd3);
  assign cmd_go       = cmd_write && cmd_valid;
  assign we_last      = cyc_cnt == 8'(WE_LOW_CYCLES - 1);
  assign rd_last      = cyc_cnt == 8'(READ_WAIT_CYCLE);
  assign poll_timeout = !sr[7] && (poll_cnt == PW'(POLL_LIMIT));
  assign poll_exit    = sr[7] || poll_timeout;

  // State register.
  // NOTE: reset is synchronous and active-high here because this block lives
  // on the board-level clock domain that already distributes a synchronous rst.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: bus-cycle phases chained by the sequence slot.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_next
    // unassigned and no latch is inferred.
    state_next = state;
    unique case (state)
      ST_IDLE:    if (cmd_go) state_next = ST_W_SETUP;
      ST_W_SETUP: state_next = ST_W_LOW;
      ST_W_LOW:   if (we_last) state_next = ST_W_HOLD;
      ST_W_HOLD:  state_next = ST_W_REC;
      ST_W_REC: begin
        if (seq_idx == IDX_ARRAY)
          state_next = ST_DONE;
        else if (seq_idx == IDX_CONFIRM && (cmd == CMD_PROG || cmd == CMD_ERASE))
          state_next = ST_R_ACT;
        else
          state_next = ST_W_SETUP;
      end
      ST_R_ACT:   if (rd_last) state_next = ST_R_REC;
      ST_R_REC:   state_next = poll_exit ? ST_W_SETUP : ST_R_ACT;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Flash pin drive: strobes, address and data are decoded from the phase.
  always_comb begin
    flash_ce_b = 1'b1;
    flash_oe_b = 1'b1;
    flash_we_b = 1'b1;
    flash_dq_o = 16'h0000;
    flash_a    = 27'd0;
    drive      = 1'b0;
    unique case (state)
      ST_W_SETUP, ST_W_HOLD: begin
        flash_ce_b = 1'b0;
        drive      = 1'b1;
        flash_dq_o = write_word;
        flash_a    = {addr[26:1], 1'b0};
      end
      ST_W_LOW: begin
        flash_ce_b = 1'b0;
        flash_we_b = 1'b0;
        drive      = 1'b1;
        flash_dq_o = write_word;
        flash_a    = {addr[26:1], 1'b0};
      end
      ST_R_ACT: begin
        flash_ce_b = 1'b0;
        flash_oe_b = 1'b0;
        flash_a    = {addr[26:1], 1'b0};
      end
      ST_W_REC, ST_R_REC: flash_a = {addr[26:1], 1'b0};
      default: ;
    endcase
  end

  assign flash_dq_t = {16{~drive}};

  // Word written in the current slot, selected by slot and command.
  always_comb begin
    write_word = 16'h00FF;
    unique case (seq_idx)
      3'd0: write_word = 16'h0050;
      3'd1: begin
        if (cmd == CMD_PROG)       write_word = 16'h0040;
        else if (cmd == CMD_ERASE) write_word = 16'h0020;
        else                       write_word = 16'h0060;
      end
      3'd2:    write_word = (cmd == CMD_PROG) ? data : 16'h00D0;
      default: write_word = 16'h00FF;
    endcase
  end

  // Software-visible ADDR/DATA; frozen while an operation is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= 27'd0;
      data <= 16'h0000;
    end else if (wr_access && !busy) begin
      if (paddr[3:2] == REG_ADDR) addr <= pwdata[26:0];
      if (paddr[3:2] == REG_DATA) data <= pwdata[15:0];
    end
  end

  // Accepted command code and position within its sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd     <= 2'd0;
      seq_idx <= 3'd0;
    end else if (cmd_go) begin
      cmd     <= pwdata[1:0];
      seq_idx <= 3'd0;
    end else if (state == ST_W_REC) begin
      if (seq_idx == IDX_CONFIRM && !(cmd == CMD_PROG || cmd == CMD_ERASE))
        seq_idx <= IDX_ARRAY;
      else
        seq_idx <= seq_idx + 3'd1;
    end else if (state == ST_R_REC && poll_exit) begin
      seq_idx <= IDX_ARRAY;
    end
  end

  // Phase timer: restarts whenever the phase changes.
  always_ff @(posedge clk) begin
    if (rst)                      cyc_cnt <= 8'd0;
    else if (state_next != state) cyc_cnt <= 8'd0;
    else                          cyc_cnt <= cyc_cnt + 8'd1;
  end

  // STATUS flags, captured SR byte and poll counter. A new command wipes the
  // previous result, including the SR byte, so STATUS reflects only it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= 8'h00;
      done     <= 1'b0;
      error    <= 1'b0;
      poll_cnt <= '0;
    end else begin
      if (cmd_write) begin
        done     <= !cmd_valid;
        error    <= !cmd_valid;
        sr       <= 8'h00;
        poll_cnt <= '0;
      end
      if (state == ST_R_ACT && rd_last) begin
        sr       <= flash_dq_i[7:0];
        poll_cnt <= poll_cnt + PW'(1);
        if (flash_dq_i[7] && (flash_dq_i[5:1] != 5'd0)) error <= 1'b1;
      end
      if (state == ST_R_REC && poll_timeout) error <= 1'b1;
      if (state == ST_W_REC && seq_idx == IDX_ARRAY) done <= 1'b1;
    end
  end

  // APB read mux, driven only during the access phase of a read.
  always_comb begin
    prdata = 32'd0;
    if (rd_access) begin
      unique case (paddr[3:2])
        REG_ADDR:   prdata = {5'd0, addr};
        REG_DATA:   prdata = {16'd0, data};
        REG_STATUS: prdata = {16'd0, sr, 5'd0, error, done, busy};
        default:    prdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ariane_emc_prog.sv
// Directed bench for ariane_emc_prog: a default-parameter instance with a
// scripted status-register flash model, plus a POLL_LIMIT=4 instance whose
// flash never reports ready, sharing the same APB bus.
module tb_ariane_emc_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        flash_wait = 1'b0;

  logic [31:0] prdata, l_prdata;
  logic        pready, l_pready, pslverr, l_pslverr;
  logic [15:0] dq_in, dq_o, dq_t;
  logic [26:0] fa;
  logic        we_b, oe_b, ce_b, adv_b;
  logic [15:0] l_dq_in = 16'h0000;
  logic [15:0] l_dq_o, l_dq_t;
  logic [26:0] l_fa;
  logic        l_we_b, l_oe_b, l_ce_b, l_adv_b;

  int n_checks = 0;
  int n_err    = 0;

  ariane_emc_prog dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .flash_dq_i(dq_in), .flash_dq_o(dq_o),
    .flash_dq_t(dq_t), .flash_a(fa), .flash_we_b(we_b), .flash_oe_b(oe_b),
    .flash_ce_b(ce_b), .flash_adv_b(adv_b), .flash_wait(flash_wait)
  );

  ariane_emc_prog #(.POLL_LIMIT(4)) dut_lim (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(l_prdata), .pready(l_pready),
    .pslverr(l_pslverr), .flash_dq_i(l_dq_in), .flash_dq_o(l_dq_o),
    .flash_dq_t(l_dq_t), .flash_a(l_fa), .flash_we_b(l_we_b),
    .flash_oe_b(l_oe_b), .flash_ce_b(l_ce_b), .flash_adv_b(l_adv_b),
    .flash_wait(flash_wait)
  );

  always #5 clk = ~clk;

  // ---------------- flash models ----------------
  logic [26:0] w_addr[$];
  logic [15:0] w_data[$];
  int          w_low[$];
  int          w_drv[$];
  int          r_len[$];
  int          r_wpos[$];
  logic [15:0] resp[0:7];
  int          resp_n    = 1;
  int          resp_base = 0;
  int          drv_cnt = 0, low_cnt = 0, oe_cnt = 0;
  logic [26:0] cur_a;
  logic [15:0] cur_d;

  always @(negedge clk) begin
    int k;
    if (rst) begin
      drv_cnt = 0; low_cnt = 0; oe_cnt = 0;
    end else begin
      if (dq_t == 16'h0000) begin
        drv_cnt++;
        if (!we_b) begin low_cnt++; cur_a = fa; cur_d = dq_o; end
      end else if (drv_cnt != 0) begin
        w_addr.push_back(cur_a); w_data.push_back(cur_d);
        w_low.push_back(low_cnt); w_drv.push_back(drv_cnt);
        drv_cnt = 0; low_cnt = 0;
      end
      if (!oe_b) oe_cnt++;
      else if (oe_cnt != 0) begin
        r_len.push_back(oe_cnt); r_wpos.push_back(w_data.size()); oe_cnt = 0;
      end
    end
    k = r_len.size() - resp_base;
    if (k >= resp_n) k = resp_n - 1;
    dq_in = resp[k];
  end

  int          lim_writes = 0, lim_reads = 0, lim_rpos = 0;
  int          l_drv = 0, l_oe = 0;
  logic [15:0] l_wd, lim_last;

  always @(negedge clk) begin
    if (rst) begin
      l_drv = 0; l_oe = 0;
    end else begin
      if (l_dq_t == 16'h0000) begin l_drv++; l_wd = l_dq_o; end
      else if (l_drv != 0) begin lim_writes++; lim_last = l_wd; l_drv = 0; end
      if (!l_oe_b) l_oe++;
      else if (l_oe != 0) begin lim_reads++; lim_rpos = lim_writes; l_oe = 0; end
    end
  end

  // ---------------- checking and bus tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1 check("pready wr", {31'd0, pready}, 32'd1);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic [31:0] dl);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata; dl = l_prdata;
    check("pready rd", {31'd0, pready}, 32'd1);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s, sl;
    int n = 0;
    do begin
      apb_read(32'hC, s, sl);
      n++;
    end while ((s[0] | sl[0]) && n < 200);
    check({tag, " idle"}, {31'd0, s[0] | sl[0]}, 32'd0);
  endtask

  task automatic set_resp1(input logic [15:0] v);
    resp[0] = v; resp_n = 1; resp_base = r_len.size();
  endtask

  // Four writes at one address, the given number of 7-cycle reads, and the
  // poll placed after the third write.
  task automatic check_seq(input string tag, input int wb, input int rb,
                           input logic [26:0] a, input logic [15:0] e0,
                           input logic [15:0] e1, input logic [15:0] e2,
                           input int nreads);
    logic [15:0] ew[4];
    ew[0] = e0; ew[1] = e1; ew[2] = e2; ew[3] = 16'h00FF;
    check({tag, " writes"}, w_data.size() - wb, 4);
    check({tag, " reads"}, r_len.size() - rb, nreads);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s w%0d data", tag, i), w_data[wb+i], ew[i]);
      check($sformatf("%s w%0d addr", tag, i), w_addr[wb+i], a);
      check($sformatf("%s w%0d we_low", tag, i), w_low[wb+i], 3);
      check($sformatf("%s w%0d drive", tag, i), w_drv[wb+i], 5);
    end
    for (int i = 0; i < nreads; i++)
      check($sformatf("%s r%0d len", tag, i), r_len[rb+i], 7);
    check({tag, " poll pos"}, r_wpos[rb] - wb, 3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, dl;
    int wb, rb, lw, lr, n, ce_low;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0;
    for (int i = 0; i < 8; i++) resp[i] = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    check("rst strobes", {29'd0, ce_b, oe_b, we_b}, 32'd7);
    check("rst dq_t", dq_t, 32'hFFFF);
    check("rst dq_o", dq_o, 32'd0);
    check("rst flash_a", fa, 32'd0);
    check("rst prdata", prdata, 32'd0);
    check("rst pready", {31'd0, pready}, 32'd1);
    check("adv_b/pslverr", {30'd0, adv_b, pslverr}, 32'd0);
    rst = 1'b0;

    apb_read(32'hC, d, dl);
    check("status after rst", d, 32'h0);
    apb_write(32'h0, 32'h0012346);
    apb_read(32'h0, d, dl);
    check("addr readback", d, 32'h0012346);
    apb_read(32'h8, d, dl);
    check("cmd reads 0", d, 32'h0);

    // Program, ready on first poll.
    apb_write(32'h4, 32'h0000BEEF);
    set_resp1(16'h0080);
    wb = w_data.size(); rb = r_len.size();
    apb_write(32'h8, 32'd1);
    wait_idle("prog");
    check_seq("prog", wb, rb, 27'h0012346, 16'h0050, 16'h0040, 16'hBEEF, 1);
    apb_read(32'hC, d, dl);
    check("prog status", d, 32'h8002);

    // Erase, ready with SR5 on the sixth poll.
    resp[0] = 16'h0000; resp[1] = 16'h0000; resp[2] = 16'h0000;
    resp[3] = 16'h0000; resp[4] = 16'h0000; resp[5] = 16'h00A0;
    resp_n = 6; resp_base = r_len.size();
    wb = w_data.size(); rb = r_len.size();
    apb_write(32'h8, 32'd2);
    wait_idle("erase");
    check_seq("erase", wb, rb, 27'h0012346, 16'h0050, 16'h0020, 16'h00D0, 6);
    apb_read(32'hC, d, dl);
    check("erase status", d, 32'hA006);

    // Writes while busy are dropped.
    apb_write(32'h0, 32'h0000100);
    set_resp1(16'h0080);
    wb = w_data.size(); rb = r_len.size();
    apb_write(32'h8, 32'd1);
    apb_write(32'h8, 32'd1);
    apb_write(32'h0, 32'h7777776);
    apb_write(32'h4, 32'h00001234);
    apb_read(32'h0, d, dl);
    check("addr held busy", d, 32'h0000100);
    wait_idle("busy");
    check_seq("busy", wb, rb, 27'h0000100, 16'h0050, 16'h0040, 16'hBEEF, 1);
    apb_read(32'hC, d, dl);
    check("busy status", d, 32'h8002);
    apb_read(32'h4, d, dl);
    check("data held busy", d, 32'h0000BEEF);

    // Unknown command: flags only, no bus activity.
    wb = w_data.size(); rb = r_len.size();
    apb_write(32'h8, 32'd7);
    ce_low = 0;
    repeat (8) begin
      @(negedge clk);
      if (!ce_b) ce_low++;
    end
    check("bad cmd ce_b", ce_low, 0);
    apb_read(32'hC, d, dl);
    check("bad cmd status", d, 32'h0006);
    check("bad cmd status lim", dl, 32'h0006);
    check("bad cmd bus", (w_data.size() - wb) + (r_len.size() - rb), 0);

    // Poll timeout on the POLL_LIMIT=4 instance.
    set_resp1(16'h0080);
    lw = lim_writes; lr = lim_reads;
    apb_write(32'h8, 32'd1);
    wait_idle("tmo");
    check("tmo reads", lim_reads - lr, 4);
    check("tmo writes", lim_writes - lw, 4);
    check("tmo poll pos", lim_rpos - lw, 3);
    check("tmo last word", lim_last, 32'h00FF);
    apb_read(32'hC, d, dl);
    check("tmo status", dl, 32'h0006);
    check("tmo ref status", d, 32'h8002);

    // Reset during the we_b-low phase.
    apb_write(32'h8, 32'd1);
    n = 0;
    while (we_b !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("we_b low seen", {31'd0, we_b}, 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst strobes", {29'd0, ce_b, oe_b, we_b}, 32'd7);
    check("midrst dq_t", dq_t, 32'hFFFF);
    check("midrst flash_a", fa, 32'd0);
    rst = 1'b0;
    apb_read(32'hC, d, dl);
    check("midrst status", d, 32'h0);
    apb_read(32'h0, d, dl);
    check("midrst addr", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
